// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage core's inter-stage registers.
// - Stage payload structs; the instantiating stage packs one of these into
//   the opaque DATA_W-bit payload of pipe_skid_stage.
// - Payload widths derived from the structs.
// - NOP_PAYLOAD, the all-zero payload an idle stage presents downstream.
// No ports: package only.
package pipe_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [7:0]  alu_op;
        logic [11:0] csr_addr;
        logic [2:0]  mem_op;
        logic        reg_we;
        logic        csr_we;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic [2:0]  mem_op;
        logic        reg_we;
    } ex_mem_t;

    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);

    // Widest payload any stage may request; NOP_PAYLOAD is sliced down to
    // the actual DATA_W by each stage instance.
    localparam int NOP_MAX_W = 1024;
    localparam logic [NOP_MAX_W-1:0] NOP_PAYLOAD = '0;

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter for the perf-counter CSRs.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, clears the count
//   inc   - amount to add this cycle (0..2)
//   count - current count; sticks at all-ones once reached
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W:0]   sum;

    // One extra bit catches the carry out; any carry means we passed the top.
    always_comb begin
        sum      = {1'b0, cnt_reg} + {{(CNT_W-1){1'b0}}, inc};
        cnt_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign count = cnt_reg;

endmodule

// File: rtl/pipe_skid_stage.sv
// Parametrised inter-stage pipeline register with optional skid entry.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - upstream handshake, in_data payload
//   out_valid/out_ready - downstream handshake, out_data head payload
//                         (all-zero while out_valid=0)
//   trap_flush          - kill all contents, overrides hold
//   hold                - freeze contents, no enqueue/dequeue
//   flush               - kill all contents (ignored during hold)
//   occupancy           - number of valid entries
//   stall_cnt           - cycles with a head present but not consumed
//   drop_cnt            - entries killed by flush/trap_flush
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              trap_flush,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    generate
        if (DEPTH != 1 && DEPTH != 2) begin : g_bad_depth
            $error("pipe_skid_stage: DEPTH must be 1 or 2");
        end
        if (DATA_W > NOP_MAX_W) begin : g_bad_width
            $error("pipe_skid_stage: DATA_W exceeds NOP_MAX_W");
        end
    endgenerate

    logic              head_valid_reg, head_valid_next;
    logic              skid_valid_reg, skid_valid_next;
    logic [DATA_W-1:0] head_data_reg, head_data_next;
    logic [DATA_W-1:0] skid_data_reg, skid_data_next;

    logic       kill;
    logic       deq;
    logic       enq;
    logic       ready_raw;
    logic [1:0] occ;
    logic [1:0] stall_inc;
    logic [1:0] drop_inc;

    assign occ  = {1'b0, head_valid_reg} + {1'b0, skid_valid_reg};
    // trap_flush wins over hold; plain flush only acts when not holding.
    assign kill = trap_flush | (flush & ~hold);

    generate
        if (DEPTH == 1) begin : g_ready_pass
            // Single entry: space exists if empty or the head leaves now.
            assign ready_raw = ~head_valid_reg | out_ready;
        end else begin : g_ready_reg
            // Skid: ready depends on state only, breaking the out_ready path.
            assign ready_raw = ~skid_valid_reg;
        end
    endgenerate

    assign in_ready = ~rst & ~hold & ready_raw;

    assign deq = head_valid_reg & out_ready & ~hold & ~kill;
    assign enq = in_valid & in_ready & ~kill;

    always_comb begin
        head_valid_next = head_valid_reg;
        head_data_next  = head_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        if (kill) begin
            head_valid_next = 1'b0;
            head_data_next  = NOP_PAYLOAD[DATA_W-1:0];
            skid_valid_next = 1'b0;
            skid_data_next  = NOP_PAYLOAD[DATA_W-1:0];
        end else if (!hold) begin
            if (deq) begin
                // Skid (if any) advances to the head.
                head_valid_next = skid_valid_reg;
                head_data_next  = skid_data_reg;
                skid_valid_next = 1'b0;
            end
            if (enq) begin
                if (!head_valid_next) begin
                    head_valid_next = 1'b1;
                    head_data_next  = in_data;
                end else if (DEPTH == 2) begin
                    skid_valid_next = 1'b1;
                    skid_data_next  = in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_valid_reg <= 1'b0;
            head_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
        end else begin
            head_valid_reg <= head_valid_next;
            head_data_reg  <= head_data_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
        end
    end

    assign out_valid = head_valid_reg;
    assign out_data  = head_valid_reg ? head_data_reg : NOP_PAYLOAD[DATA_W-1:0];
    assign occupancy = occ;

    // Hold cycles count as stalls; kill cycles do not.
    assign stall_inc = {1'b0, head_valid_reg & ~kill & (hold | ~out_ready)};
    assign drop_inc  = kill ? occ : 2'b00;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .count (drop_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: three instances share one stimulus stream
// (DEPTH=2, DEPTH=1, and DEPTH=2 with 4-bit counters). Each has a queue
// reference model; accepted beats are pushed, consumed beats popped.
module tb_pipe_skid_stage;

    typedef logic [31:0] word_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  in_valid, out_ready, hold, flush, trap_flush;
    word_t in_data;

    logic        ir2, ov2, ir1, ov1, irs, ovs;
    word_t       od2, od1, ods;
    logic [1:0]  occ2, occ1, occs;
    logic [31:0] st2, dr2, st1, dr1;
    logic [3:0]  sts, drs;

    logic stim_done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    word_t  q2[$];
    word_t  q1[$];
    longint stall2, drop2, stall1, drop1;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(32), .DEPTH(2), .CNT_W(32)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .trap_flush(trap_flush),
        .hold(hold), .flush(flush), .occupancy(occ2), .stall_cnt(st2), .drop_cnt(dr2));

    pipe_skid_stage #(.DATA_W(32), .DEPTH(1), .CNT_W(32)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .trap_flush(trap_flush),
        .hold(hold), .flush(flush), .occupancy(occ1), .stall_cnt(st1), .drop_cnt(dr1));

    pipe_skid_stage #(.DATA_W(32), .DEPTH(2), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irs), .in_data(in_data),
        .out_valid(ovs), .out_ready(out_ready), .out_data(ods), .trap_flush(trap_flush),
        .hold(hold), .flush(flush), .occupancy(occs), .stall_cnt(sts), .drop_cnt(drs));

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat15(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    // Check current outputs against the model, then advance the model by the
    // transition the coming clock edge will perform.
    task automatic step(input int depth, input string tag, ref word_t q[$],
                        ref longint stall, ref longint drop,
                        input logic a_ir, input logic a_ov, input word_t a_od,
                        input logic [1:0] a_occ, input logic [31:0] a_st,
                        input logic [31:0] a_dr);
        int    sz;
        logic  exp_ir;
        word_t head;
        sz   = q.size();
        head = (sz > 0) ? q[0] : 32'h0;
        if (hold)            exp_ir = 1'b0;
        else if (depth == 1) exp_ir = (sz == 0) || out_ready;
        else                 exp_ir = (sz < 2);
        chk({tag, "_in_ready"},  a_ir,  exp_ir);
        chk({tag, "_out_valid"}, a_ov,  sz > 0);
        chk({tag, "_occupancy"}, a_occ, sz);
        chk({tag, "_out_data"},  a_od,  head);
        chk({tag, "_stall_cnt"}, a_st,  stall);
        chk({tag, "_drop_cnt"},  a_dr,  drop);
        if (trap_flush || (flush && !hold)) begin
            drop += sz;
            q.delete();
        end else if (hold) begin
            if (sz > 0) stall++;
        end else begin
            if (sz > 0 && !out_ready) stall++;
            if (sz > 0 && out_ready) begin
                $display("%s deq data=%08h t=%0t", tag, q[0], $time);
                void'(q.pop_front());
            end
            if (in_valid && exp_ir) q.push_back(in_data);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            q2.delete(); q1.delete();
            stall2 = 0; drop2 = 0; stall1 = 0; drop1 = 0;
            chk("rst_d2_in_ready", ir2, 0);
            chk("rst_d1_in_ready", ir1, 0);
            chk("rst_d2_out_valid", ov2, 0);
            chk("rst_d2_out_data", od2, 0);
            chk("rst_d2_occupancy", occ2, 0);
            chk("rst_d2_stall", st2, 0);
            chk("rst_d2_drop", dr2, 0);
            chk("rst_sat_stall", sts, 0);
        end else begin
            // The 4-bit instance follows the DEPTH=2 model, counters clipped.
            chk("sat_in_ready", irs, ir2);
            chk("sat_out_valid", ovs, q2.size() > 0);
            chk("sat_out_data", ods, (q2.size() > 0) ? q2[0] : 32'h0);
            chk("sat_occupancy", occs, q2.size());
            chk("sat_stall_cnt", sts, sat15(stall2));
            chk("sat_drop_cnt", drs, sat15(drop2));
            step(2, "d2", q2, stall2, drop2, ir2, ov2, od2, occ2, st2, dr2);
            step(1, "d1", q1, stall1, drop1, ir1, ov1, od1, occ1, st1, dr1);
        end
        if (stim_done) begin
            chk("sat_stall_final", sts, 15);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    task automatic cyc(input logic iv, input word_t d, input logic ordy,
                       input logic hl, input logic fl, input logic tr);
        @(posedge clk);
        #1;
        in_valid = iv; in_data = d; out_ready = ordy;
        hold = hl; flush = fl; trap_flush = tr;
    endtask

    // Driver
    initial begin
        rst = 1'b1;
        in_valid = 0; in_data = 0; out_ready = 0; hold = 0; flush = 0; trap_flush = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Beat in flight, then a mid-cycle reset pulse wipes it.
        cyc(1, 32'h99, 0, 0, 0, 0);
        @(posedge clk);
        #1 in_valid = 0; out_ready = 0;
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;

        // Fill with out_ready low.
        cyc(1, 32'h11, 0, 0, 0, 0);
        cyc(1, 32'h22, 0, 0, 0, 0);
        cyc(1, 32'h33, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);

        // Flush a full stage with a beat offered.
        cyc(1, 32'h44, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Hold beats flush.
        cyc(1, 32'hAA, 0, 0, 0, 0);
        repeat (3) cyc(1, 32'h55, 1, 1, 1, 0);

        // Trap beats hold.
        cyc(1, 32'hBB, 0, 0, 0, 0);
        cyc(1, 32'h66, 0, 1, 0, 1);

        // Streaming.
        for (int i = 1; i <= 8; i++) cyc(1, word_t'(i), 1, 0, 0, 0);
        repeat (2) cyc(0, 0, 1, 0, 0, 0);

        // Long stall to saturate the 4-bit counter.
        cyc(1, 32'h77, 0, 0, 0, 0);
        repeat (20) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 39) == 0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        stim_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL timeout no summary reached");
        $fatal(1, "timeout");
    end

endmodule
